// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the spi_ram_arb round-robin RAM port arbiter.
// Optional read-data timeout is enabled by defining SPI_RAM_ARB_TIMEOUT_EN.
package spi_ram_arb_pkg;

  // Largest supported requester count; sets the grant index width.
  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = $clog2(NREQ_MAX);

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  // Width of the read-data timeout counter (TO_CYC must fit).
  localparam int TO_W = 16;
`endif

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  // Next requester index after cur, wrapping at n.
  function automatic idx_t next_idx(idx_t cur, int n);
    return (int'(cur) + 1 >= n) ? '0 : idx_t'(cur + idx_t'(1));
  endfunction

endpackage

// File: rtl/spi_ram_arb_if.sv
// Bus bundle for spi_ram_arb: NREQ requester ports plus the shared RAM port.
// slave = arbiter view, master = requesters + RAM controller view.
interface spi_ram_arb_if #(
  parameter int NREQ = 2,
  parameter int AW   = 20
);

  // Requester side
  logic [NREQ-1:0]          req_rd;
  logic [NREQ-1:0]          req_wr;
  logic [NREQ-1:0][3:0]     req_rlen4;
  logic [NREQ-1:0][3:0]     req_wlen4;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][31:0]    req_wdata;
  logic [NREQ-1:0]          req_bus_ready;
  logic [NREQ-1:0]          req_rdata_ready;
  logic [31:0]              req_rdata;

  // RAM controller side
  logic                     ram_rd;
  logic                     ram_wr;
  logic [3:0]               ram_rlen4;
  logic [3:0]               ram_wlen4;
  logic [AW-1:0]            ram_addr;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;
  logic                     ram_bus_ready;
  logic                     ram_rdata_ready;

  modport slave (
    input  req_rd, req_wr, req_rlen4, req_wlen4, req_addr, req_wdata,
    output req_bus_ready, req_rdata_ready, req_rdata,
    output ram_rd, ram_wr, ram_rlen4, ram_wlen4, ram_addr, ram_wdata,
    input  ram_rdata, ram_bus_ready, ram_rdata_ready
  );

  modport master (
    output req_rd, req_wr, req_rlen4, req_wlen4, req_addr, req_wdata,
    input  req_bus_ready, req_rdata_ready, req_rdata,
    input  ram_rd, ram_wr, ram_rlen4, ram_wlen4, ram_addr, ram_wdata,
    output ram_rdata, ram_bus_ready, ram_rdata_ready
  );

endinterface

// File: rtl/spi_ram_arb_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after ptr,
// wrapping from NREQ-1 back to 0.
module spi_ram_arb_rr_pick
  import spi_ram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output idx_t            idx,
  output logic            any
);

  // Search [ptr..NREQ-1] first, then wrap to [0..ptr-1].
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (idx_t'(i) >= ptr)) begin
        idx = idx_t'(i);
        any = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (idx_t'(i) < ptr)) begin
        idx = idx_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_ram_arb.sv
// spi_ram_arb: round-robin arbiter sharing one 32-bit RAM port among NREQ
// masters. The grant is held for a whole transaction (write until
// ram_bus_ready, read until ram_rdata_ready). No data buffering.
// Optional macro SPI_RAM_ARB_TIMEOUT_EN adds a read-data timeout (TO_CYC).
module spi_ram_arb
  import spi_ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 20
`ifdef SPI_RAM_ARB_TIMEOUT_EN
  ,
  parameter int TO_CYC = 255
`endif
) (
  input  logic          clk,
  input  logic          rstn,
  spi_ram_arb_if.slave  bus,
  output idx_t          gnt_id,
  output logic          busy,
  output logic          err_timeout
);

  state_t          state_q, state_d;
  idx_t            gnt_q, gnt_d;
  idx_t            rr_ptr_q;
  idx_t            pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] req_act;

  // Fields of the currently granted requester
  logic            sel_rd, sel_wr;
  logic [3:0]      sel_rlen4, sel_wlen4;
  logic [AW-1:0]   sel_addr;
  logic [31:0]     sel_wdata;

  // Strobes for the granted requester before one-hot routing
  logic            bus_ready_g;
  logic            rdata_ready_g;
  logic            to_hit;

  assign req_act = bus.req_rd | bus.req_wr;

  spi_ram_arb_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (req_act),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  // Timeout counter: held at 0 outside RDATA, counts each RDATA cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_RDATA) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // TO_CYC-th RDATA cycle without data: give up on this read.
  assign to_hit = (state_q == ST_RDATA) && !bus.ram_rdata_ready &&
                  (to_cnt_q == TO_W'(TO_CYC - 1));
  assign bus.req_rdata = to_hit ? '0 : bus.ram_rdata;
`else
  assign to_hit        = 1'b0;
  assign bus.req_rdata = bus.ram_rdata;
`endif

  assign err_timeout = to_hit;
  assign gnt_id      = gnt_q;
  assign busy        = (state_q != ST_IDLE);

  // Mux the granted requester's command fields.
  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_rlen4 = '0;
    sel_wlen4 = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == idx_t'(i)) begin
        sel_rd    = bus.req_rd[i];
        sel_wr    = bus.req_wr[i];
        sel_rlen4 = bus.req_rlen4[i];
        sel_wlen4 = bus.req_wlen4[i];
        sel_addr  = bus.req_addr[i];
        sel_wdata = bus.req_wdata[i];
      end
    end
  end

  // FSM next state, grant capture and RAM command outputs.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    bus_ready_g   = 1'b0;
    rdata_ready_g = 1'b0;
    bus.ram_rd    = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.ram_rlen4 = '0;
    bus.ram_wlen4 = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        // Write wins if a requester raises both commands.
        bus.ram_wr    = sel_wr;
        bus.ram_rd    = sel_rd & ~sel_wr;
        bus.ram_rlen4 = sel_rlen4;
        bus.ram_wlen4 = sel_wlen4;
        bus.ram_addr  = sel_addr;
        bus.ram_wdata = sel_wdata;
        bus_ready_g   = bus.ram_bus_ready;
        if (bus.ram_bus_ready && sel_wr) begin
          state_d = ST_IDLE;
        end else if (bus.ram_bus_ready && sel_rd) begin
          state_d = ST_RDATA;
        end else if (!(sel_rd || sel_wr)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        rdata_ready_g = bus.ram_rdata_ready | to_hit;
        if (rdata_ready_g) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route handshake strobes to the granted requester only.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_bus_ready[i]   = bus_ready_g   && (gnt_q == idx_t'(i));
      bus.req_rdata_ready[i] = rdata_ready_g && (gnt_q == idx_t'(i));
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      // Every return to IDLE (abandon included) moves priority past the winner.
      if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
        rr_ptr_q <= next_idx(gnt_q, NREQ);
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arb.sv
// Self-checking bench for spi_ram_arb: scoreboard of expected RAM commands
// and read returns, one task per scenario.
module tb_spi_ram_arb;
  import spi_ram_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 20;

  logic clk = 1'b0;
  logic rstn;
  idx_t gnt_id;
  logic busy;
  logic err_timeout;

  spi_ram_arb_if #(.NREQ(NREQ), .AW(AW)) bus ();

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  spi_ram_arb #(.NREQ(NREQ), .AW(AW), .TO_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .gnt_id(gnt_id), .busy(busy), .err_timeout(err_timeout)
  );
`else
  spi_ram_arb #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .gnt_id(gnt_id), .busy(busy), .err_timeout(err_timeout)
  );
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [31:0] data;
  } rdat_t;

  cmd_t  cmd_q[$];
  rdat_t rdat_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic cmd_t obs_cmd();
    return {bus.ram_wr, bus.ram_rd, gnt_id, bus.ram_addr, bus.ram_wdata};
  endfunction

  function automatic logic [1:0] onehot(int g);
    return 2'(1 << g);
  endfunction

  task automatic clear_inputs();
    bus.req_rd          = '0;
    bus.req_wr          = '0;
    bus.req_rlen4       = '0;
    bus.req_wlen4       = '0;
    bus.req_addr        = '0;
    bus.req_wdata       = '0;
    bus.ram_rdata       = '0;
    bus.ram_bus_ready   = 1'b0;
    bus.ram_rdata_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    cmd_q.delete();
    rdat_q.delete();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Wait up to budget falling edges for a RAM command; ok=0 on expiry.
  task automatic wait_cmd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ram_rd || bus.ram_wr) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({busy, gnt_id, err_timeout} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_status: busy/gnt/err got %b expected 0000", {busy, gnt_id, err_timeout});
    end
    n_vec++;
    if ({bus.ram_rd, bus.ram_wr, bus.ram_rlen4, bus.ram_wlen4, bus.ram_addr, bus.ram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_ram_cmd: got rd=%b wr=%b addr=%h wdata=%h expected all 0",
               bus.ram_rd, bus.ram_wr, bus.ram_addr, bus.ram_wdata);
    end
    n_vec++;
    if ({bus.req_bus_ready, bus.req_rdata_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus.req_bus_ready, bus.req_rdata_ready});
    end
  endtask

  task automatic test_single_write();
    cmd_t exp, got;
    do_reset();
    @(negedge clk);
    bus.req_wr       = 2'b01;
    bus.req_addr[0]  = 20'h00010;
    bus.req_wdata[0] = 32'hA5A5A5A5;
    bus.req_wlen4[0] = 4'hF;
    cmd_q.push_back('{wr: 1'b1, rd: 1'b0, gnt: 2'd0, addr: 20'h00010, data: 32'hA5A5A5A5});
    #1;
    n_vec++;
    if (bus.ram_wr !== 1'b0) begin
      n_err++;
      $display("FAIL write_idle_no_cmd: ram_wr got %b expected 0", bus.ram_wr);
    end
    @(negedge clk);
    got = obs_cmd();
    exp = cmd_q.pop_front();
    n_vec++;
    if (got !== exp || bus.ram_wlen4 !== 4'hF) begin
      n_err++;
      $display("FAIL write_cmd: got %h wlen %h expected %h wlen f", got, bus.ram_wlen4, exp);
    end
    bus.ram_bus_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_bus_ready !== 2'b01) begin
      n_err++;
      $display("FAIL write_bus_ready: got %b expected 01", bus.req_bus_ready);
    end
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL write_done_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_contention();
    cmd_t  exp, got;
    rdat_t rexp;
    bit    ok;
    int    g;
    do_reset();
    @(negedge clk);
    bus.req_rd      = 2'b11;
    bus.req_rlen4   = {4'hF, 4'hF};
    bus.req_addr[0] = 20'h00100;
    bus.req_addr[1] = 20'h00200;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      cmd_q.push_back('{wr: 1'b0, rd: 1'b1, gnt: 2'(g), addr: (g == 0) ? 20'h00100 : 20'h00200, data: 32'h0});
      rdat_q.push_back('{gnt: 2'(g), data: 32'hD000_0000 + 32'(k)});
      wait_cmd(4, ok);
      exp = cmd_q.pop_front();
      rexp = rdat_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL contention_wait: no RAM command for grant %0d within 4 cycles", k);
        break;
      end
      got = obs_cmd();
      if (got !== exp) begin
        n_err++;
        $display("FAIL contention_cmd[%0d]: got %h expected %h", k, got, exp);
      end
      bus.ram_bus_ready = 1'b1;
      #1;
      n_vec++;
      if (bus.req_bus_ready !== onehot(g)) begin
        n_err++;
        $display("FAIL contention_bus_ready[%0d]: got %b expected %b", k, bus.req_bus_ready, onehot(g));
      end
      @(negedge clk);
      bus.ram_bus_ready = 1'b0;
      if (k == 0) begin
        n_vec++;
        if (bus.ram_rd !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL rdata_no_cmd: ram_rd=%b busy=%b expected 0,1", bus.ram_rd, busy);
        end
      end
      @(negedge clk);
      bus.ram_rdata       = rexp.data;
      bus.ram_rdata_ready = 1'b1;
      #1;
      n_vec++;
      if (bus.req_rdata_ready !== onehot(int'(rexp.gnt)) || bus.req_rdata !== rexp.data) begin
        n_err++;
        $display("FAIL contention_rdata[%0d]: got rdy=%b data=%h expected rdy=%b data=%h",
                 k, bus.req_rdata_ready, bus.req_rdata, onehot(int'(rexp.gnt)), rexp.data);
      end
      @(negedge clk);
      bus.ram_rdata_ready = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_abandon();
    cmd_t exp, got;
    do_reset();
    @(negedge clk);
    // Completed write by requester 0 moves priority to requester 1.
    bus.req_wr       = 2'b01;
    bus.req_addr[0]  = 20'h00020;
    bus.req_wdata[0] = 32'h0000_0001;
    @(negedge clk);
    bus.ram_bus_ready = 1'b1;
    @(negedge clk);
    bus.ram_bus_ready = 1'b0;
    bus.req_wr        = 2'b10;
    bus.req_addr[1]   = 20'h00300;
    bus.req_wdata[1]  = 32'h1234_5678;
    cmd_q.push_back('{wr: 1'b1, rd: 1'b0, gnt: 2'd1, addr: 20'h00300, data: 32'h1234_5678});
    @(negedge clk);
    got = obs_cmd();
    exp = cmd_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL abandon_cmd: got %h expected %h", got, exp);
    end
    bus.req_wr = 2'b00;
    #1;
    n_vec++;
    if (bus.req_bus_ready !== 2'b00 || bus.ram_wr !== 1'b0) begin
      n_err++;
      $display("FAIL abandon_drop: bus_ready=%b ram_wr=%b expected 00,0", bus.req_bus_ready, bus.ram_wr);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bus.req_bus_ready !== 2'b00) begin
      n_err++;
      $display("FAIL abandon_idle: busy=%b bus_ready=%b expected 0,00", busy, bus.req_bus_ready);
    end
    bus.req_rd = 2'b11;
    @(negedge clk);
    n_vec++;
    if (gnt_id !== 2'd0 || bus.ram_rd !== 1'b1) begin
      n_err++;
      $display("FAIL abandon_rr_ptr: gnt=%0d ram_rd=%b expected 0,1", gnt_id, bus.ram_rd);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_rd_wr_same();
    cmd_t exp, got;
    do_reset();
    @(negedge clk);
    bus.req_rd       = 2'b01;
    bus.req_wr       = 2'b01;
    bus.req_addr[0]  = 20'h00040;
    bus.req_wdata[0] = 32'hCAFE_F00D;
    cmd_q.push_back('{wr: 1'b1, rd: 1'b0, gnt: 2'd0, addr: 20'h00040, data: 32'hCAFE_F00D});
    @(negedge clk);
    got = obs_cmd();
    exp = cmd_q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rdwr_cmd: got %h expected %h", got, exp);
    end
    bus.ram_rdata_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_rdata_ready !== 2'b00) begin
      n_err++;
      $display("FAIL rdata_outside_rdata: got %b expected 00", bus.req_rdata_ready);
    end
    bus.ram_rdata_ready = 1'b0;
    bus.ram_bus_ready   = 1'b1;
    @(negedge clk);
    clear_inputs();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rdwr_no_rdata: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_rdata();
    do_reset();
    @(negedge clk);
    bus.req_rd      = 2'b10;
    bus.req_addr[1] = 20'h00500;
    @(negedge clk);
    bus.ram_bus_ready = 1'b1;
    @(negedge clk);
    bus.ram_bus_ready = 1'b0;
    bus.req_rd        = 2'b00;
    n_vec++;
    if (busy !== 1'b1 || gnt_id !== 2'd1 || bus.ram_rd !== 1'b0) begin
      n_err++;
      $display("FAIL rdata_wait: busy=%b gnt=%0d ram_rd=%b expected 1,1,0", busy, gnt_id, bus.ram_rd);
    end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({busy, gnt_id, bus.req_bus_ready, bus.req_rdata_ready, bus.ram_rd, bus.ram_wr} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_rdata: busy=%b gnt=%0d rdy=%b rdrdy=%b expected all 0",
               busy, gnt_id, bus.req_bus_ready, bus.req_rdata_ready);
    end
    @(negedge clk);
    rstn                = 1'b1;
    bus.ram_rdata       = 32'h0000_0BAD;
    bus.ram_rdata_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_rdata_ready !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL late_rdata_ignored: rdrdy=%b busy=%b expected 00,0", bus.req_rdata_ready, busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bus.req_rdata_ready !== 2'b00) begin
      n_err++;
      $display("FAIL late_rdata_idle: busy=%b rdrdy=%b expected 0,00", busy, bus.req_rdata_ready);
    end
    clear_inputs();
  endtask

`ifdef SPI_RAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  hit_at;
    bit  early;
    do_reset();
    @(negedge clk);
    bus.req_rd      = 2'b01;
    bus.req_addr[0] = 20'h00600;
    @(negedge clk);
    bus.ram_bus_ready = 1'b1;
    @(negedge clk);
    bus.ram_bus_ready = 1'b0;
    bus.req_rd        = 2'b00;
    bus.ram_rdata     = 32'hDEAD_BEEF;
    hit_at = 0;
    early  = 1'b0;
    // k counts RDATA cycles starting at 1.
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (err_timeout === 1'b1) begin
        hit_at = k;
        n_vec++;
        if (bus.req_rdata_ready !== 2'b01 || bus.req_rdata !== 32'h0) begin
          n_err++;
          $display("FAIL timeout_strobe: rdrdy=%b rdata=%h expected 01,00000000",
                   bus.req_rdata_ready, bus.req_rdata);
        end
        break;
      end
      if (bus.req_rdata_ready !== 2'b00) early = 1'b1;
    end
    n_vec++;
    if (hit_at != 16 || early) begin
      n_err++;
      $display("FAIL timeout_cycle: pulse at %0d early_rdy=%b expected 16,0", hit_at, early);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle: busy=%b err=%b expected 0,0", busy, err_timeout);
    end
    clear_inputs();
  endtask
`else
  task automatic test_no_timeout();
    bit seen_err;
    bit left_rdata;
    do_reset();
    @(negedge clk);
    bus.req_rd      = 2'b01;
    bus.req_addr[0] = 20'h00600;
    @(negedge clk);
    bus.ram_bus_ready = 1'b1;
    @(negedge clk);
    bus.ram_bus_ready = 1'b0;
    bus.req_rd        = 2'b00;
    seen_err   = 1'b0;
    left_rdata = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (err_timeout !== 1'b0) seen_err = 1'b1;
      if (busy !== 1'b1 || bus.req_rdata_ready !== 2'b00) left_rdata = 1'b1;
    end
    n_vec++;
    if (seen_err || left_rdata) begin
      n_err++;
      $display("FAIL no_timeout_wait: err_seen=%b left_rdata=%b expected 0,0", seen_err, left_rdata);
    end
    bus.ram_rdata       = 32'h5555_AAAA;
    bus.ram_rdata_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.req_rdata_ready !== 2'b01 || bus.req_rdata !== 32'h5555_AAAA) begin
      n_err++;
      $display("FAIL no_timeout_rdata: rdrdy=%b rdata=%h expected 01,5555aaaa",
               bus.req_rdata_ready, bus.req_rdata);
    end
    @(negedge clk);
    clear_inputs();
  endtask
`endif

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_abandon();
    test_rd_wr_same();
    test_reset_rdata();
`ifdef SPI_RAM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
